// File: rtl/dmem_uart_pkg.sv
// Shared definitions for the rv32i data-side bridge: MMIO map, STATUS layout and TX states.
package dmem_uart_pkg;

    localparam int          MMIO_BIT     = 31;
    localparam logic [31:0] OFF_TXDATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS   = 32'h0000_0004;
    localparam logic [1:0]  REG_TXDATA   = OFF_TXDATA[3:2];
    localparam logic [1:0]  REG_STATUS   = OFF_STATUS[3:2];

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: pops one byte from the upstream FIFO per frame and shifts it out LSB first.
module uart_tx
    import dmem_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              bit_end;

    assign bit_end  = (baud_cnt == '0);
    // A pop in STOP lets the next start bit follow the stop bit with no idle gap.
    assign fifo_pop = fifo_valid && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (fifo_valid) begin
                        state    <= START;
                        baud_cnt <= BAUD_LAST;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_LAST;
                        bit_cnt  <= '0;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (fifo_valid) begin
                            state    <= START;
                            baud_cnt <= BAUD_LAST;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Shift register is pure data: loaded on pop, advanced at each data-bit boundary.
    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            shift_reg <= fifo_data;
        end else if ((state == DATA) && bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

endmodule

// File: rtl/dmem_uart_bridge.sv
// MEM-stage data slave: byte-maskable word RAM below 0x8000_0000, UART TX registers above.
module dmem_uart_bridge
    import dmem_uart_pkg::*;
#(
    parameter int RAM_WORDS    = 1024,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc,
    output logic        op_uart_tx
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] ram_idx;
    logic          is_mmio;
    logic [1:0]    reg_sel;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;
    logic          tx_busy;
    logic [31:0]   status;
    logic          unused_addr;

    function automatic logic [ST_COUNT_W-1:0] sat_count(input logic [PW:0] c);
        logic [31:0] c32;
        c32 = 32'(c);
        return (c32 > 32'd15) ? 4'hF : c32[3:0];
    endfunction

    assign ram_idx     = ip_data_addr[AW+1:2];
    assign is_mmio     = ip_data_addr[MMIO_BIT];
    assign reg_sel     = ip_data_addr[3:2];
    assign unused_addr = ^{ip_data_addr[MMIO_BIT-1:AW+2], ip_data_addr[1:0]};

    assign full     = (count == FIFO_FULL);
    assign empty    = (count == '0);
    assign push_req = ip_data_wr && is_mmio && (reg_sel == REG_TXDATA) && ip_data_mask[0];
    // A full FIFO still accepts a byte when the transmitter drains one in the same cycle.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = ip_data_wr && is_mmio && (reg_sel == REG_STATUS) && ip_data_mask[0]
                      && ip_data_from_proc[ST_OVERFLOW];

    always_ff @(posedge clk) begin
        if (ip_data_wr && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (ip_data_mask[i]) begin
                    ram[ram_idx][8*i +: 8] <= ip_data_from_proc[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ip_data_from_proc[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            // Set has priority so a clear cannot hide an overflow in the same cycle.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status                                = '0;
        status[ST_FULL]                       = full;
        status[ST_EMPTY]                      = empty;
        status[ST_BUSY]                       = tx_busy;
        status[ST_OVERFLOW]                   = overflow;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = sat_count(count);
    end

    always_comb begin
        op_data_to_proc = '0;
        if (!is_mmio) begin
            op_data_to_proc = ram[ram_idx];
        end else if (reg_sel == REG_STATUS) begin
            op_data_to_proc = status;
        end
    end

    assign op_data_valid = ip_data_rd;

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk        (clk),
        .reset      (reset),
        .fifo_valid (!empty),
        .fifo_data  (fifo_mem[rd_ptr]),
        .fifo_pop   (pop),
        .tx         (op_uart_tx),
        .busy       (tx_busy)
    );

endmodule

// File: tb/tb_dmem_uart_bridge.sv
// Bench for dmem_uart_bridge: bus-level RAM/MMIO checks plus a serial-line scoreboard.
`timescale 1ns/1ps
module tb_dmem_uart_bridge;

    localparam int          CPB       = 4;
    localparam int          RAM_WORDS = 1024;
    localparam int          FRAME     = 10 * CPB;
    localparam logic [31:0] A_TX      = 32'h8000_0000;
    localparam logic [31:0] A_ST      = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ip_data_addr = '0;
    logic        ip_data_wr = 1'b0;
    logic [3:0]  ip_data_mask = '0;
    logic [31:0] ip_data_from_proc = '0;
    logic        ip_data_rd = 1'b0;
    logic        op_data_valid;
    logic [31:0] op_data_to_proc;
    logic        op_uart_tx;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];
    int          rst_epoch = 0;

    dmem_uart_bridge #(
        .RAM_WORDS    (RAM_WORDS),
        .FIFO_DEPTH   (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ip_data_addr      (ip_data_addr),
        .ip_data_wr        (ip_data_wr),
        .ip_data_mask      (ip_data_mask),
        .ip_data_from_proc (ip_data_from_proc),
        .ip_data_rd        (ip_data_rd),
        .op_data_valid     (op_data_valid),
        .op_data_to_proc   (op_data_to_proc),
        .op_uart_tx        (op_uart_tx)
    );

    always #5 clk = ~clk;

    always @(negedge reset) rst_epoch = rst_epoch + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Expected line level j cycles after a start bit begins.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j < CPB) return 1'b0;
        if (j < 9 * CPB) return b[(j - CPB) / CPB];
        return 1'b1;
    endfunction

    // Serial receiver: samples mid-bit, pops the expected byte, drops frames cut by reset.
    initial begin : serial_monitor
        logic [7:0] rx;
        logic [7:0] exp_b;
        logic       start_ok;
        logic       stop_ok;
        int         ep;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && op_uart_tx === 1'b0) begin
                ep = rst_epoch;
                rx = '0;
                repeat (CPB / 2) @(negedge clk);
                start_ok = (op_uart_tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx[i] = op_uart_tx;
                end
                repeat (CPB) @(negedge clk);
                stop_ok = (op_uart_tx === 1'b1);
                if (rst_epoch == ep) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL uart_frame: got byte %02h but nothing was queued", rx);
                    end else begin
                        exp_b = sb.pop_front();
                        if (rx !== exp_b || !start_ok || !stop_ok) begin
                            n_err++;
                            $display("FAIL uart_frame: got %02h start_ok=%b stop_ok=%b, expected %02h with good start/stop",
                                     rx, start_ok, stop_ok, exp_b);
                        end
                    end
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        ip_data_addr      = addr;
        ip_data_from_proc = data;
        ip_data_mask      = mask;
        ip_data_wr        = 1'b1;
        @(posedge clk);
        #1;
        ip_data_wr   = 1'b0;
        ip_data_mask = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic valid);
        ip_data_addr = addr;
        ip_data_rd   = 1'b1;
        @(negedge clk);
        data  = op_data_to_proc;
        valid = op_data_valid;
        @(posedge clk);
        #1;
        ip_data_rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (op_uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx: got %b, expected 1", op_uart_tx);
        end
        n_cmp++;
        if (op_data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid_idle: got %b, expected 0", op_data_valid);
        end
        @(posedge clk);
        #1;
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h2 || v !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status: got %h valid %b, expected 00000002 valid 1", d, v);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL status_after_release: got %h, expected 00000002", d);
        end
    endtask

    task automatic test_ram_bytes();
        logic [31:0] d;
        logic        v;
        bus_write(32'h10, 32'hAABB_CCDD, 4'b1111);
        bus_write(32'h10, 32'h00EE_0000, 4'b0100);
        bus_read(32'h10, d, v);
        n_cmp++;
        if (d !== 32'hAAEE_CCDD || v !== 1'b1) begin
            n_err++;
            $display("FAIL ram_lane2: got %h valid %b, expected aaeeccdd valid 1", d, v);
        end
        bus_write(32'h14, 32'h1122_3344, 4'b1111);
        bus_write(32'h14, 32'hFFFF_FFFF, 4'b1000);
        bus_write(32'h14, 32'h0000_00AA, 4'b0001);
        bus_read(32'h14, d, v);
        n_cmp++;
        if (d !== 32'hFF22_33AA) begin
            n_err++;
            $display("FAIL ram_lane0_3: got %h, expected ff2233aa", d);
        end
    endtask

    task automatic test_alias_reserved();
        logic [31:0] d;
        logic        v;
        bus_write(32'h10 + RAM_WORDS * 4, 32'h1234_5678, 4'b1111);
        bus_read(32'h10, d, v);
        n_cmp++;
        if (d !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL ram_alias: got %h, expected 12345678", d);
        end
        bus_write(32'h8, 32'hCAFE_F00D, 4'b1111);
        bus_write(32'h8000_0008, 32'hFFFF_FFFF, 4'b1111);
        bus_read(32'h8000_0008, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reserved_read: got %h, expected 00000000", d);
        end
        bus_read(32'h8, d, v);
        n_cmp++;
        if (d !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL reserved_no_ram: got %h, expected cafef00d", d);
        end
        bus_read(A_TX, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL txdata_read: got %h, expected 00000000", d);
        end
        bus_write(A_TX, 32'h41, 4'b0000);
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL no_push_without_lane0: got %h, expected 00000002", d);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        logic        tx_k1;
        logic        line[48];
        int          bad;
        logic        v;
        bus_write(A_TX, 32'h55, 4'b0001);
        sb.push_back(8'h55);
        ip_data_addr = A_ST;
        ip_data_rd   = 1'b1;
        @(negedge clk);
        d     = op_data_to_proc;
        tx_k1 = op_uart_tx;
        @(posedge clk);
        #1;
        ip_data_rd = 1'b0;
        n_cmp++;
        if (d !== 32'h10 || tx_k1 !== 1'b1) begin
            n_err++;
            $display("FAIL push_latency: status %h tx %b, expected 00000010 tx 1", d, tx_k1);
        end
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            line[j] = op_uart_tx;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (line[0] !== 1'b0) begin
            n_err++;
            $display("FAIL start_two_cycles: got tx %b, expected 0", line[0]);
        end
        bad = 0;
        for (int j = 0; j < 48; j++) begin
            if (line[j] !== frame_bit(8'h55, j)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL frame_55_line: %0d wrong cycles, expected 0", bad);
        end
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL status_after_frame: got %h, expected 00000002", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        logic        line[88];
        int          bad;
        logic        exp_l;
        bus_write(A_TX, 32'h01, 4'b0001);
        sb.push_back(8'h01);
        bus_write(A_TX, 32'h80, 4'b0001);
        sb.push_back(8'h80);
        for (int j = 0; j < 88; j++) begin
            @(negedge clk);
            line[j] = op_uart_tx;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (line[FRAME - 1] !== 1'b1 || line[FRAME] !== 1'b0) begin
            n_err++;
            $display("FAIL no_gap: stop end %b next start %b, expected 1 then 0", line[FRAME - 1], line[FRAME]);
        end
        bad = 0;
        for (int j = 0; j < 88; j++) begin
            if (j < FRAME) exp_l = frame_bit(8'h01, j);
            else exp_l = frame_bit(8'h80, j - FRAME);
            if (line[j] !== exp_l) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL b2b_line_80: %0d wrong cycles, expected 0", bad);
        end
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL status_after_b2b: got %h, expected 00000002", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic        v;
        int          waited;
        // Byte 0 moves to the shifter right after it lands, so bytes 1..8 fill the FIFO and byte 9 is lost.
        for (int i = 0; i < 10; i++) begin
            bus_write(A_TX, 32'hC0 + i, 4'b0001);
            if (i < 9) sb.push_back(8'hC0 + 8'(i));
        end
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== (32'h01 | 32'h04 | 32'h08 | (32'd8 << 4))) begin
            n_err++;
            $display("FAIL overflow_status: got %h, expected 0000008d", d);
        end
        bus_write(A_ST, 32'h08, 4'b0010);
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h8D) begin
            n_err++;
            $display("FAIL overflow_kept_no_lane0: got %h, expected 0000008d", d);
        end
        bus_write(A_ST, 32'h08, 4'b0001);
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h85) begin
            n_err++;
            $display("FAIL overflow_clear: got %h, expected 00000085", d);
        end
        waited = 0;
        while (sb.size() != 0 && waited < 12 * FRAME) begin
            @(posedge clk);
            waited++;
        end
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL overflow_drain: %0d frames outstanding after %0d cycles, expected 0", sb.size(), waited);
        end
        repeat (4) @(posedge clk);
        #1;
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL status_after_drain: got %h, expected 00000002", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic        v;
        int          bad;
        bus_write(A_TX, 32'hA5, 4'b0001);
        sb.push_back(8'hA5);
        repeat (18) @(posedge clk);
        #3;
        n_cmp++;
        if (op_uart_tx !== 1'b0) begin
            n_err++;
            $display("FAIL data_bit3_before_reset: got %b, expected 0", op_uart_tx);
        end
        reset = 1'b0;
        sb.delete();
        #1;
        n_cmp++;
        if (op_uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_tx: got %b, expected 1", op_uart_tx);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus_read(A_ST, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL status_after_midreset: got %h, expected 00000002", d);
        end
        bad = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (op_uart_tx !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL residual_frame: %0d low cycles after reset, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_ram_bytes();
        test_alias_reserved();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: %0d bytes never seen, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
